// File: rtl/conv5x5_window.sv
// 5x5 sliding window over the five-line tap bus with a double-buffered signed
// kernel, pipelined MAC, rounding, shift and 8-bit saturation (latency 6).
module conv5x5_window #(
    parameter int COEFF_W = 12,
    parameter int SHIFT   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pa,
    input  logic [7:0]         pb,
    input  logic [7:0]         pc,
    input  logic [7:0]         pd,
    input  logic [7:0]         pe,
    input  logic               stat_in,
    input  logic               coeff_we,
    input  logic [4:0]         coeff_addr,
    input  logic [COEFF_W-1:0] coeff_data,
    input  logic               coeff_commit,
    output logic [7:0]         data_o,
    output logic               stat_o
);

    localparam int PROD_W = 9 + COEFF_W;
    localparam int ACC_W  = COEFF_W + 14;
    localparam logic signed [COEFF_W-1:0] UNITY = COEFF_W'(1 << SHIFT);
    localparam logic signed [ACC_W-1:0]   RND   = ACC_W'((1 << SHIFT) >> 1);

    logic [7:0]                win [5][5];
    logic signed [COEFF_W-1:0] shadow [25];
    logic signed [COEFF_W-1:0] active [25];
    logic signed [PROD_W-1:0]  prod [25];
    logic signed [ACC_W-1:0]   row_sum [5];
    logic signed [ACC_W-1:0]   row_next [5];
    logic signed [ACC_W-1:0]   total;
    logic signed [ACC_W-1:0]   total_next;
    logic signed [ACC_W-1:0]   rounded;
    logic signed [ACC_W-1:0]   shifted;
    logic [7:0]                pix_next;
    logic [5:0]                stat_dly;

    // Column 0 holds the newest column; row 0 is the newest line (pa).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < 5; r++)
                for (int unsigned c = 0; c < 5; c++)
                    win[r][c] <= '0;
        end else begin
            win[0][0] <= pa;
            win[1][0] <= pb;
            win[2][0] <= pc;
            win[3][0] <= pd;
            win[4][0] <= pe;
            for (int unsigned r = 0; r < 5; r++)
                for (int unsigned c = 1; c < 5; c++)
                    win[r][c] <= win[r][c-1];
        end
    end

    // Commit copies the pre-edge shadow, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 25; i++) begin
                shadow[i] <= (i == 12) ? UNITY : '0;
                active[i] <= (i == 12) ? UNITY : '0;
            end
        end else begin
            if (coeff_we && coeff_addr <= 5'd24)
                shadow[coeff_addr] <= coeff_data;
            if (coeff_commit)
                for (int unsigned i = 0; i < 25; i++)
                    active[i] <= shadow[i];
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < 5; r++) begin
            row_next[r] = '0;
            for (int unsigned c = 0; c < 5; c++)
                row_next[r] = row_next[r] + ACC_W'(prod[r*5+c]);
        end
        total_next = '0;
        for (int unsigned r = 0; r < 5; r++)
            total_next = total_next + row_sum[r];
    end

    always_comb begin
        rounded  = total + RND;
        shifted  = rounded >>> SHIFT;
        pix_next = shifted[7:0];
        if (shifted[ACC_W-1])
            pix_next = 8'h00;
        else if (shifted > ACC_W'(255))
            pix_next = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 25; i++)
                prod[i] <= '0;
            for (int unsigned r = 0; r < 5; r++)
                row_sum[r] <= '0;
            total  <= '0;
            data_o <= '0;
        end else begin
            for (int unsigned r = 0; r < 5; r++)
                for (int unsigned c = 0; c < 5; c++)
                    prod[r*5+c] <= $signed({1'b0, win[r][c]}) * active[r*5+c];
            for (int unsigned r = 0; r < 5; r++)
                row_sum[r] <= row_next[r];
            total  <= total_next;
            data_o <= pix_next;
        end
    end

    // Six delay stages plus the output register match the seven data-path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dly <= '0;
            stat_o   <= 1'b0;
        end else begin
            stat_dly <= {stat_dly[4:0], stat_in};
            stat_o   <= stat_dly[5];
        end
    end

endmodule

// File: doc/conv5x5_window.md
Name: conv5x5_window

Overview:
- Consumer of the five-line vertical tap bus (pa newest line … pe oldest line) produced by the line-buffer delay chain in the HDMI convolution filter path.
- Builds a 5x5 pixel window with horizontal shift registers and applies a programmable signed 5x5 kernel through a fixed-latency pipelined MAC.
- Rounds, shifts and saturates the result to an 8-bit pixel, and delays the status bit to stay aligned with the output pixel.
- Kernel coefficients are double-buffered: shadow bank written by control logic, active bank updated on commit.

Parameters:
COEFF_W, 12, signed coefficient width in bits.
SHIFT, 8, fractional bits of coefficients; 1<<SHIFT = gain 1.0; legal range 0..COEFF_W-2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
pa  input  8  newest-line pixel, unsigned.
pb  input  8  line-1 pixel.
pc  input  8  line-2 pixel (centre row).
pd  input  8  line-3 pixel.
pe  input  8  oldest-line pixel.
stat_in  input  1  status bit accompanying the tap column.
coeff_we  input  1  shadow coefficient write strobe.
coeff_addr  input  5  coefficient index = row*5+col; row 0 = pa, col 0 = newest column; 0..24 valid.
coeff_data  input  COEFF_W  signed coefficient value.
coeff_commit  input  1  pulse: copy shadow bank to active bank.
data_o  output  8  filtered pixel.
stat_o  output  1  stat_in delayed by LAT.

Behaviour:
- Clock and reset: one clock (clk); rst synchronous, active-high.
- Reset state:
  - Window registers, pipeline registers, stat delay line, data_o and stat_o all = 0.
  - Shadow and active banks = identity kernel: index 12 = 1<<SHIFT, all others 0.
- Window:
  - Every cycle, the column {pa..pe} is captured into column 0; columns 0..3 shift into 1..4.
  - There is no gating; data flows continuously.
- Pipeline stages, each registered:
  - S1: 25 products, pixel zero-extended to 9-bit signed times active coefficient; product width 9+COEFF_W.
  - S2: five row sums.
  - S3: total sum; ACC_W = COEFF_W+14, no overflow possible.
  - S4: output register.
    - If SHIFT>0, add 1<<(SHIFT-1); then arithmetic right-shift by SHIFT.
    - Clamp: <0 -> 0, >255 -> 255.
    - Result registered to data_o.
- Latency:
  - A column sampled at edge n reaches centre column 2 at edge n+2.
  - data_o for that centre pixel appears after edge n+6; LAT = 6.
  - stat_o = stat_in sampled at edge n, appearing after edge n+6 (6-deep shift register).
- Coefficient writes:
  - coeff_we=1 with coeff_addr<=24 writes shadow[coeff_addr] at that edge.
  - coeff_addr 25..31 is ignored: no bank changes.
- Commit:
  - coeff_commit=1 at edge m copies the whole shadow bank to the active bank at edge m.
  - The copy uses shadow contents from before edge m; a write in the same cycle lands in shadow only and takes effect at the next commit.
  - Products use the new active bank from edge m+1; data_o first reflects the new kernel after edge m+4.
  - No partial kernel is ever visible at the output.
- Commit every cycle is legal: the active bank tracks shadow with 1 cycle lag.
- Reset mid-stream:
  - Restores the reset state in one edge and discards any pending writes.
  - Output is 0 until valid data propagates, i.e. 6 cycles after the first post-reset input.
- Window edges: the block performs no border handling; upstream status marks invalid border pixels.

Test Plan:
- Reset, then drive pc = 0,1,2,… per cycle (other taps 0), stat_in = 1 at every 4th sample -> data_o equals pc delayed exactly 6 cycles, stat_o equals stat_in delayed 6; identity kernel.
- Write all 25 coeffs = 10, commit, constant input 200 on all taps -> data_o = (50000+128)>>8 = 195 in steady state.
- Centre coeff = 1024, others 0, commit, input 100 -> data_o = 255; centre coeff = -256, input 50 -> data_o = 0.
- Write shadow with box kernel, hold coeff_commit=0 for 20 cycles -> output stays identity; pulse commit at edge m -> output changes after edge m+4, never earlier.
- In the same cycle, write index 12 = 512 and commit, then write coeff_addr = 27 with data 999 -> the first commit keeps the old index 12; a second commit applies 512 (gain 2); address 27 changes nothing.
- Assert rst for 1 cycle mid-stream with a non-identity kernel active -> data_o/stat_o = 0 the next cycle, and the identity kernel is active afterwards.
